ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/core_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/ifetch.sv | 136 +++++++++++++
 tb/tb_ifetch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-side types: data widths, fetch FSM states and the buffered instruction entry.
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic            fault;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] data;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; the low two address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of arbitrary entry type; used both as the instruction buffer and the tag queue.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues word-aligned requests under a credit limit, buffers in-order
// responses for decode, drops stale responses after a redirect and halts on an access fault.
module ifetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    input  logic             imem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [ILEN-1:0]  inst_data,
    output logic [XLEN-1:0]  inst_pc,
    output logic             inst_fault
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   tag_count;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] tag_pc;
    logic            tag_full;
    logic            tag_empty;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    buf_head;
    fetch_entry_t    buf_wdata;
    logic            req_fire;
    logic            rsp_accept;
    logic            rsp_keep;
    logic            buf_pop;

    // Dropped responses still hold a credit until they return, so they are part of inflight.
    assign occupancy      = {1'b0, tag_count} + {1'b0, buf_count};
    assign imem_req_valid = !rst && (state == RUN) && !tag_full && !buf_full
                            && (occupancy < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_accept = imem_rsp_valid && !tag_empty;
    assign rsp_keep   = rsp_accept && (drop_cnt == '0) && !redirect_valid;
    assign buf_pop    = inst_valid && inst_ready;

    always_comb begin
        buf_wdata       = '0;
        buf_wdata.fault = imem_rsp_err;
        buf_wdata.pc    = tag_pc;
        buf_wdata.data  = imem_rsp_data;
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_accept),
        .head      (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (fetch_entry_t)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_valid),
        .push      (rsp_keep),
        .push_data (buf_wdata),
        .pop       (buf_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= align_pc(redirect_pc);
        else if (req_fire)
            fetch_pc <= fetch_pc + XLEN'(4);
    end

    // Everything still outstanding at a redirect, including this cycle's handshake, is stale.
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (redirect_valid)
            drop_cnt <= tag_count + CW'(req_fire) - CW'(rsp_accept);
        else if (rsp_accept && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect_valid)
            state_next = RUN;
        else if (rsp_keep && imem_rsp_err)
            state_next = HALT;
    end

    assign inst_valid = !rst && !buf_empty;
    assign inst_data  = inst_valid ? buf_head.data  : '0;
    assign inst_pc    = inst_valid ? buf_head.pc    : '0;
    assign inst_fault = inst_valid ? buf_head.fault : 1'b0;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: in-order memory model plus an epoch-based reference of the
// delivered instruction stream, directed scenarios, a redirect vector table and a random phase.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;

    always #5 clk = ~clk;

    ifetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } ent_t;

    typedef struct {
        logic [31:0] target;
        int          lat;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } redir_vec_t;

    req_t        memq[$];
    ent_t        bufq[$];
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          epoch  = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] m_fetch_pc;
    logic [31:0] stream_pc;
    logic [31:0] fault_addr;
    bit          m_halted;
    bit          fault_en;
    bit          fault_pat;
    bit          popped;
    logic [31:0] pop_pc;
    logic        pop_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return (fault_en && (a == fault_addr)) || (fault_pat && (a[7:2] == 6'h2B));
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: drive inputs, compare outputs at the falling edge, advance the model.
    task automatic apply_stimulus(input bit r, input bit redir, input logic [31:0] rpc,
                                  input bit rq_ready, input bit i_ready);
        bit   exp_valid;
        bit   exp_req;
        bit   fire;
        bit   rsp;
        req_t h;
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_ready;
        inst_ready     = i_ready;
        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        if (rsp) begin
            imem_rsp_data = mem_word(memq[0].addr);
            imem_rsp_err  = is_fault(memq[0].addr);
        end else begin
            imem_rsp_data = $urandom;
            imem_rsp_err  = 1'b0;
        end
        popped = 0;
        @(negedge clk);
        if (r) begin
            check_output("rst_req_valid",  32'(imem_req_valid), 32'd0);
            check_output("rst_inst_valid", 32'(inst_valid),     32'd0);
            check_output("rst_inst_data",  inst_data,           32'd0);
            check_output("rst_inst_pc",    inst_pc,             32'd0);
            check_output("rst_inst_fault", 32'(inst_fault),     32'd0);
            memq.delete();
            bufq.delete();
            epoch++;
            m_fetch_pc = RESET_PC;
            stream_pc  = RESET_PC;
            m_halted   = 0;
        end else begin
            exp_valid = (bufq.size() > 0);
            exp_req   = !m_halted && ((memq.size() + bufq.size()) < DEPTH);
            check_output("inst_valid", 32'(inst_valid), 32'(exp_valid));
            if (exp_valid) begin
                check_output("inst_pc",    inst_pc,         bufq[0].pc);
                check_output("inst_data",  inst_data,       bufq[0].data);
                check_output("inst_fault", 32'(inst_fault), 32'(bufq[0].fault));
            end
            check_output("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_req)
                check_output("req_addr", imem_req_addr, m_fetch_pc);
            if (exp_valid && i_ready) begin
                popped    = 1;
                pop_pc    = inst_pc;
                pop_fault = inst_fault;
                check_output("stream_order", inst_pc, stream_pc);
                stream_pc = stream_pc + 32'd4;
                void'(bufq.pop_front());
            end
            fire = exp_req && rq_ready;
            if (rsp) begin
                h = memq.pop_front();
                if ((h.epoch == epoch) && !redir) begin
                    bufq.push_back('{h.addr, mem_word(h.addr), is_fault(h.addr)});
                    if (is_fault(h.addr))
                        m_halted = 1;
                end
            end
            if (fire)
                memq.push_back('{m_fetch_pc, epoch, cyc + int'($urandom_range(lat_min, lat_max))});
            if (redir) begin
                bufq.delete();
                epoch++;
                m_fetch_pc = {rpc[31:2], 2'b00};
                stream_pc  = m_fetch_pc;
                m_halted   = 0;
            end else if (fire) begin
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pop(input string name, output logic [31:0] pc, output logic flt);
        bit got = 0;
        pc  = '0;
        flt = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (popped) begin
                got = 1;
                pc  = pop_pc;
                flt = pop_fault;
            end
        end
        if (!got)
            check_output({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    redir_vec_t  vecs[4];
    logic [31:0] pc;
    logic        flt;
    int          npops;
    int          need;
    bit          got;

    initial begin
        vecs[0] = '{32'h0000_0100, 3, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0103, 2, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h0000_02A7, 4, 32'h0000_02A4, 32'h0000_02A8};

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
        m_fetch_pc = RESET_PC; stream_pc = RESET_PC; fault_addr = '0;
        m_halted = 0; fault_en = 0; fault_pat = 0; pop_pc = '0; pop_fault = 1'b0;
        @(posedge clk);
        #1;

        // Streaming at one-cycle memory latency
        repeat (2) apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        wait_pop("stream_first", pc, flt);
        check_output("stream_first_pc", pc, RESET_PC);
        npops = 0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (popped) npops++;
        end
        check_output("stream_rate", 32'(npops), 32'd16);

        // Decode stalls: credits run out, nothing lost after release
        repeat (10) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_output("bp_req_low",    32'(imem_req_valid), 32'd0);
        check_output("bp_inst_valid", 32'(inst_valid),     32'd1);
        repeat (20) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect vectors: alignment, wrap and stale-response dropping
        for (int v = 0; v < 4; v++) begin
            lat_min = vecs[v].lat;
            lat_max = vecs[v].lat;
            need = (vecs[v].lat > 1) ? 2 : 1;
            for (int i = 0; i < 20 && int'(memq.size()) < need; i++)
                apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            apply_stimulus(1'b0, 1'b1, vecs[v].target, 1'b1, 1'b1);
            wait_pop("redir_first", pc, flt);
            check_output("redir_pc0", pc, vecs[v].pc0);
            wait_pop("redir_second", pc, flt);
            check_output("redir_pc1", pc, vecs[v].pc1);
        end

        // Access fault at 0x20 halts fetch until a redirect
        lat_min = 1; lat_max = 1;
        fault_en = 1; fault_addr = 32'h0000_0020;
        repeat (2) apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (popped && (pop_pc == 32'h0000_0020)) begin
                got = 1;
                check_output("fault_flag", 32'(pop_fault), 32'd1);
            end
        end
        if (!got) check_output("fault_entry_timeout", 32'd0, 32'd1);
        repeat (8) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_output("halt_no_req", 32'(imem_req_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
        wait_pop("resume", pc, flt);
        check_output("resume_pc",    pc,        32'h0000_0040);
        check_output("resume_fault", 32'(flt),  32'd0);
        fault_en = 0;

        // Reset while responses are outstanding and the buffer holds entries
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30 && !(bufq.size() >= 1 && memq.size() >= 1
                                    && (bufq.size() + memq.size()) == DEPTH); i++)
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        wait_pop("post_rst", pc, flt);
        check_output("post_rst_pc", pc, RESET_PC);

        // Random traffic against the reference model
        lat_min = 1; lat_max = 4;
        fault_pat = 1;
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 199) == 0,
                           $urandom_range(0, 29) == 0,
                           $urandom,
                           $urandom_range(0, 3) != 0,
                           $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
